ex_muldiv_unit: RTL

- Execute-stage iterative multiply/divide unit for the 5-stage MIPS pipeline.
- Consumes operands and the decoded muldiv op latched by the ID/EX pipeline register.
- Owns the architectural HI/LO registers.
- Drives a busy stall toward the hazard unit; the ID/EX register holds the next MFHI/MFLO/muldiv until HI/LO are final.

---
 rtl/ex_muldiv_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS execute-stage multiply/divide unit that owns HI/LO.
// Define MULDIV_MADD_EN to accept MADD/MADDU (accumulate into {hi,lo}).
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            r,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  input  logic            mthi,
  input  logic            mtlo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   mag_b;
  logic              is_div;
  logic              sign_p;   // product / quotient sign
  logic              sign_r;   // remainder sign
  logic              div_zero;
`ifdef MULDIV_MADD_EN
  logic              is_madd;
`endif

  logic              op_valid;
  logic              signed_op;
  logic              accept;
  logic              last;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;

  always_comb begin
    op_valid = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: op_valid = 1'b1;
`ifdef MULDIV_MADD_EN
      3'b100, 3'b101:                 op_valid = 1'b1;
`endif
      default:                        op_valid = 1'b0;
    endcase
  end

  assign signed_op = ~op[0];
  assign accept    = (state == IDLE) && start && op_valid && !flush;
  assign last      = (cnt == CW'(XLEN - 1));
  assign busy      = (state != IDLE);

  assign mag_a_in = (signed_op && opa[XLEN-1]) ? -opa : opa;
  assign mag_b_in = (signed_op && opb[XLEN-1]) ? -opb : opb;

  // Shift-add multiply: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole pair right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: shift next dividend bit into the remainder and keep the
  // difference only when it does not go negative.
  assign shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff     = shifted - {1'b0, mag_b};
  assign div_next = (shifted >= {1'b0, mag_b}) ?
                    {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} :
                    {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  // Divide by zero yields quotient all ones; the remainder path restores opa.
  assign prod_s = sign_p ? -acc : acc;
  assign quot_s = div_zero ? '1 : (sign_p ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  assign rem_s  = sign_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge r) begin
    if (!r) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cnt      <= '0;
      acc      <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      sign_p   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_MADD_EN
      is_madd  <= 1'b0;
`endif
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == FIX) && !flush;
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= {{XLEN{1'b0}}, mag_a_in};
            mag_b    <= mag_b_in;
            is_div   <= op[1];
            sign_p   <= signed_op & (opa[XLEN-1] ^ opb[XLEN-1]);
            sign_r   <= signed_op & opa[XLEN-1];
            div_zero <= (opb == '0);
            cnt      <= '0;
`ifdef MULDIV_MADD_EN
            is_madd  <= op[2];
`endif
          end else if (!start) begin
            if (mthi) hi <= opa;
            if (mtlo) lo <= opa;
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            if (is_div) begin
              lo <= quot_s;
              hi <= rem_s;
            end
`ifdef MULDIV_MADD_EN
            else if (is_madd) {hi, lo} <= {hi, lo} + prod_s;
`endif
            else {hi, lo} <= prod_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
